// File: rtl/pkg_cajero.sv
// Shared PIN verifier constants, FSM state encoding and digit validity helper.
package pkg_cajero;

  localparam int PIN_W        = 16;
  localparam int DIG_W        = 4;
  localparam int NUM_DIGITOS  = 4;
  localparam int MAX_INTENTOS = 3;
  localparam int CNT_W        = $clog2(NUM_DIGITOS);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    ESPERA_DIGITOS = 3'd1,
    VALIDAR        = 3'd2,
    PIN_OK         = 3'd3,
    BLOQUEO        = 3'd4
  } estado_t;

  function automatic logic es_digito_valido(input logic [DIG_W-1:0] d);
    return d <= DIG_W'(9);
  endfunction

endpackage

// File: rtl/captura_digitos.sv
// Keypad digit shift register with digit count; acepta/completo are combinational on the strobe.
// Digits above 9 are dropped; limpiar has priority over a simultaneous accepted digit.
module captura_digitos
  import pkg_cajero::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             limpiar,
  input  logic             habilitar,
  input  logic [DIG_W-1:0] digito,
  input  logic             digito_stb,
  output logic [PIN_W-1:0] buffer,
  output logic             acepta,
  output logic             completo
);

  logic [CNT_W-1:0] cuenta;

  assign acepta   = habilitar && digito_stb && es_digito_valido(digito);
  assign completo = acepta && (cuenta == CNT_W'(NUM_DIGITOS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buffer <= '0;
      cuenta <= '0;
    end else if (limpiar) begin
      buffer <= '0;
      cuenta <= '0;
    end else if (acepta) begin
      buffer <= {buffer[PIN_W-DIG_W-1:0], digito};
      // Count wraps after the last digit so the next attempt starts from zero.
      cuenta <= completo ? '0 : cuenta + CNT_W'(1);
    end
  end

endmodule

// File: rtl/verificador_pin.sv
// Card PIN verifier FSM with attempt counting and blocking; pin_ok rises 2 cycles after the 4th digit.
// Optional inactivity timeout between digits: define VERIFICADOR_PIN_TIMEOUT_EN.
module verificador_pin
  import pkg_cajero::*;
#(
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tarjeta_recibida,
  input  logic [PIN_W-1:0] pin_correcto,
  input  logic [DIG_W-1:0] digito,
  input  logic             digito_stb,
  output logic             pin_ok,
  output logic             pin_incorrecto,
  output logic             advertencia,
  output logic             bloqueo,
  output logic [1:0]       intentos
);

  if (TIMEOUT_CICLOS < 1) begin : g_param_invalido
    $error("TIMEOUT_CICLOS must be at least 1");
  end

  estado_t          estado, estado_sig;
  logic [1:0]       intentos_sig;
  logic             limpiar;
  logic             captura_en;
  logic             incorrecto_sig;
  logic [PIN_W-1:0] buffer;
  logic             acepta;
  logic             completo;
  logic             tmo_fin;

  captura_digitos u_captura (
    .clk        (clk),
    .reset      (reset),
    .limpiar    (limpiar),
    .habilitar  (captura_en),
    .digito     (digito),
    .digito_stb (digito_stb),
    .buffer     (buffer),
    .acepta     (acepta),
    .completo   (completo)
  );

`ifdef VERIFICADOR_PIN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CICLOS + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Held at zero outside digit entry, so entering ESPERA_DIGITOS reloads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (estado != ESPERA_DIGITOS || acepta) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_fin = (estado == ESPERA_DIGITOS) && !acepta &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CICLOS - 1));
`else
  assign tmo_fin = 1'b0;
`endif

  always_comb begin
    estado_sig     = estado;
    intentos_sig   = intentos;
    limpiar        = 1'b0;
    captura_en     = 1'b0;
    incorrecto_sig = 1'b0;
    case (estado)
      IDLE: begin
        limpiar = 1'b1;
        if (tarjeta_recibida) estado_sig = ESPERA_DIGITOS;
      end
      ESPERA_DIGITOS: begin
        if (!tarjeta_recibida) begin
          estado_sig   = IDLE;
          limpiar      = 1'b1;
          intentos_sig = 2'd0;
        end else if (tmo_fin) begin
          estado_sig = IDLE;
          limpiar    = 1'b1;
        end else begin
          captura_en = 1'b1;
          if (completo) estado_sig = VALIDAR;
        end
      end
      VALIDAR: begin
        if (!tarjeta_recibida) begin
          estado_sig   = IDLE;
          limpiar      = 1'b1;
          intentos_sig = 2'd0;
        end else if (buffer == pin_correcto) begin
          estado_sig   = PIN_OK;
          intentos_sig = 2'd0;
        end else begin
          incorrecto_sig = 1'b1;
          limpiar        = 1'b1;
          if (intentos >= 2'(MAX_INTENTOS - 1)) begin
            intentos_sig = 2'(MAX_INTENTOS);
            estado_sig   = BLOQUEO;
          end else begin
            intentos_sig = intentos + 2'd1;
            estado_sig   = ESPERA_DIGITOS;
          end
        end
      end
      PIN_OK: begin
        if (!tarjeta_recibida) estado_sig = IDLE;
      end
      BLOQUEO: begin
        estado_sig = BLOQUEO;
      end
      default: begin
        estado_sig = IDLE;
        limpiar    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado         <= IDLE;
      intentos       <= 2'd0;
      pin_ok         <= 1'b0;
      pin_incorrecto <= 1'b0;
      advertencia    <= 1'b0;
      bloqueo        <= 1'b0;
    end else begin
      estado         <= estado_sig;
      intentos       <= intentos_sig;
      // pin_ok trails state entry by one edge and drops with card removal.
      pin_ok         <= (estado == PIN_OK) && (estado_sig == PIN_OK);
      pin_incorrecto <= incorrecto_sig;
      advertencia    <= (intentos_sig == 2'(MAX_INTENTOS - 1));
      bloqueo        <= (estado_sig == BLOQUEO);
    end
  end

endmodule
